ie_loader: RTL and testbench
============================

// Module: ie_loader
// PURPOSE
//  Inverse of the instruction decoder: takes RV32 instruction fields, packs them into a 32-bit
//  instruction word, and writes the words to sequential addresses of instruction memory.
//  Used as the program loader / self-test stimulus source feeding the fetch-side memory.
//  valid/ready input handshake, 1-cycle registered write port, capacity tracking.
// PARAMETERS
//  INSTRUCTON_WIDTH  32             instruction word width (fixed RV32 layout)
//  MEM_DEPTH         256            number of words the loader may write
//  ADDR_WIDTH        $clog2(MEM_DEPTH)  width of mem_addr
// PORTS
//  clk          in   1                  clock, all logic on posedge
//  rst_n        in   1                  asynchronous active-low reset
//  start        in   1                  pulse: (re)start load at address 0
//  in_valid     in   1                  field set valid
//  in_ready     out  1                  loader accepts a field set this cycle
//  opcode       in   7                  instruction opcode
//  rd           in   5                  destination register
//  rs1          in   5                  source register 1
//  rs2          in   5                  source register 2
//  func3        in   3                  function field 3
//  func7        in   7                  function field 7 (R-type, shift-immediate)
//  imm          in   32                 immediate, unscaled byte value
//  mem_we       out  1                  instruction-memory write strobe
//  mem_addr     out  ADDR_WIDTH         word address of the write
//  mem_wdata    out  INSTRUCTON_WIDTH   encoded instruction
//  word_count   out  ADDR_WIDTH+1       words written since start
//  full         out  1                  MEM_DEPTH words accepted
//  err          out  1                  sticky: an unknown opcode was received
//  err_opcode   out  7                  opcode that first set err
// BEHAVIOUR
//  Reset (async, rst_n=0): state IDLE; in_ready, mem_we, full, err = 0; mem_addr, mem_wdata,
//   word_count, err_opcode = 0. A write pending at reset is dropped.
//  FSM: IDLE -start-> RUN; RUN -MEM_DEPTH-th valid accept-> FULL; start in RUN/FULL -> RUN
//   with word_count, write pointer, err, err_opcode cleared (same edge).
//  in_ready = (state==RUN). Accept = in_valid & in_ready. One accept per cycle, no bubbles.
//  Accept at edge N -> mem_we=1 at cycle N+1 with mem_addr = write pointer, mem_wdata = encoded
//   word; the pointer and word_count increment on the same edge as the accept. mem_we=0 otherwise.
//  Opcode classes and encodings (instr bits 31..0):
//   R  0110011,0101111: {func7,rs2,rs1,func3,rd,opcode}
//   I  0010011,0000011,1100111,1110011: {imm[11:0],rs1,func3,rd,opcode}
//      shift (0010011, func3 001/101): {func7,imm[4:0],rs1,func3,rd,opcode}
//   S  0100011: {imm[11:5],rs2,rs1,func3,imm[4:0],opcode}
//   B  1100011: {imm[12],imm[10:5],rs2,rs1,func3,imm[4:1],imm[11],opcode}
//   U  0110111,0010111: {imm[31:12],rd,opcode}
//   J  1101111: {imm[20],imm[10:1],imm[11],imm[19:12],rd,opcode}
//   Fields unused by a class are ignored. imm[0] of B/J is ignored (no misalignment check).
//  Unknown opcode: still accepted (handshake completes). No write, pointer and count unchanged.
//   err=1 from N+1; err_opcode latched only if err was 0.
//  full = (state==FULL): set on the edge of the MEM_DEPTH-th valid accept, so in_ready=0 from the
//   next cycle. That last word is still written at N+1. No wrap-around; pointer holds.
//  start coincident with in_valid: start wins, field set not accepted that cycle.
//  in_valid in IDLE/FULL is ignored.
// TESTING
//  start; add x3,x1,x2 (op 33,rd3,rs1 1,rs2 2) -> next cycle mem_we=1, addr 0, wdata 0x002081B3
//  back-to-back addi x1,x0,5 / sw x2,8(x1) / beq x1,x2,+16 / lui x5,0x12345 / jal x1,+2048 ->
//   addr 0..4, data 0x00500093, 0x0020A423, 0x00208863, 0x123452B7, 0x001000EF, no gaps
//  opcode 0x7F between two valid ops -> no write for it, err=1, err_opcode=0x7F, addresses contiguous
//  MEM_DEPTH=4, stream 5 valid ops -> 4 writes, full=1, in_ready=0, 5th held, word_count=4; start -> count 0
//  rst_n low on the accept cycle -> mem_we stays 0 asynchronously, all outputs 0, state IDLE

Source files
------------

// File: rtl/ie_loader_if.sv
// Handshake and instruction-memory write bus of the instruction loader.
// The master side supplies instruction fields; the slave side is the loader itself.
interface ie_loader_if #(
  parameter int ADDR_WIDTH       = 8,
  parameter int INSTRUCTON_WIDTH = 32
);
  logic                        start;
  logic                        in_valid;
  logic                        in_ready;
  logic [6:0]                  opcode;
  logic [4:0]                  rd;
  logic [4:0]                  rs1;
  logic [4:0]                  rs2;
  logic [2:0]                  func3;
  logic [6:0]                  func7;
  logic [31:0]                 imm;
  logic                        mem_we;
  logic [ADDR_WIDTH-1:0]       mem_addr;
  logic [INSTRUCTON_WIDTH-1:0] mem_wdata;
  logic [ADDR_WIDTH:0]         word_count;
  logic                        full;
  logic                        err;
  logic [6:0]                  err_opcode;

  modport master (
    output start, in_valid, opcode, rd, rs1, rs2, func3, func7, imm,
    input  in_ready, mem_we, mem_addr, mem_wdata, word_count, full, err, err_opcode
  );

  modport slave (
    input  start, in_valid, opcode, rd, rs1, rs2, func3, func7, imm,
    output in_ready, mem_we, mem_addr, mem_wdata, word_count, full, err, err_opcode
  );
endinterface

// File: rtl/ie_loader.sv
// Instruction loader: packs RV32 fields into instruction words and writes them
// to consecutive instruction-memory addresses, tracking capacity and bad opcodes.
module ie_loader #(
  parameter int INSTRUCTON_WIDTH = 32,
  parameter int MEM_DEPTH        = 256,
  parameter int ADDR_WIDTH       = $clog2(MEM_DEPTH)
) (
  input  logic        clk,
  input  logic        rst_n,
  ie_loader_if.slave  bus
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_FULL
  } state_t;

  localparam logic [6:0] OP_OP     = 7'b0110011;
  localparam logic [6:0] OP_AMO    = 7'b0101111;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;

  localparam logic [ADDR_WIDTH:0] LAST_COUNT = (ADDR_WIDTH+1)'(MEM_DEPTH - 1);

  state_t                      state, state_nxt;
  logic                        accept;
  logic                        known;
  logic [31:0]                 enc;
  logic [ADDR_WIDTH:0]         count;
  logic                        we_q;
  logic [ADDR_WIDTH-1:0]       addr_q;
  logic [INSTRUCTON_WIDTH-1:0] wdata_q;
  logic                        err_q;
  logic [6:0]                  err_op_q;

  // NOTE: every signal written here gets a default first, so no path leaves a
  // value unassigned and no latch is inferred.
  always_comb begin
    known = 1'b1;
    enc   = '0;
    unique case (bus.opcode)
      OP_OP, OP_AMO:
        enc = {bus.func7, bus.rs2, bus.rs1, bus.func3, bus.rd, bus.opcode};
      OP_IMM:
        // Shift-immediates carry func7 in the upper bits instead of imm[11:5].
        if (bus.func3 == 3'b001 || bus.func3 == 3'b101)
          enc = {bus.func7, bus.imm[4:0], bus.rs1, bus.func3, bus.rd, bus.opcode};
        else
          enc = {bus.imm[11:0], bus.rs1, bus.func3, bus.rd, bus.opcode};
      OP_LOAD, OP_JALR, OP_SYSTEM:
        enc = {bus.imm[11:0], bus.rs1, bus.func3, bus.rd, bus.opcode};
      OP_STORE:
        enc = {bus.imm[11:5], bus.rs2, bus.rs1, bus.func3, bus.imm[4:0], bus.opcode};
      OP_BRANCH:
        enc = {bus.imm[12], bus.imm[10:5], bus.rs2, bus.rs1, bus.func3,
               bus.imm[4:1], bus.imm[11], bus.opcode};
      OP_LUI, OP_AUIPC:
        enc = {bus.imm[31:12], bus.rd, bus.opcode};
      OP_JAL:
        enc = {bus.imm[20], bus.imm[10:1], bus.imm[11], bus.imm[19:12], bus.rd, bus.opcode};
      default:
        known = 1'b0;
    endcase
  end

  // start takes priority: a field set presented with start is not consumed.
  assign accept = bus.in_valid && (state == S_RUN) && !bus.start;

  always_comb begin
    state_nxt = state;
    if (bus.start)
      state_nxt = S_RUN;
    else if (accept && known && (count == LAST_COUNT))
      state_nxt = S_FULL;
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values, independent of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nxt;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count    <= '0;
      we_q     <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      err_q    <= 1'b0;
      err_op_q <= '0;
    end else begin
      we_q <= 1'b0;
      if (bus.start) begin
        count    <= '0;
        err_q    <= 1'b0;
        err_op_q <= '0;
      end else if (accept) begin
        if (known) begin
          we_q    <= 1'b1;
          addr_q  <= count[ADDR_WIDTH-1:0];
          wdata_q <= INSTRUCTON_WIDTH'(enc);
          count   <= count + 1'b1;
        end else begin
          err_q <= 1'b1;
          if (!err_q) err_op_q <= bus.opcode;
        end
      end
    end
  end

  assign bus.in_ready   = (state == S_RUN);
  assign bus.full       = (state == S_FULL);
  assign bus.mem_we     = we_q;
  assign bus.mem_addr   = addr_q;
  assign bus.mem_wdata  = wdata_q;
  assign bus.word_count = count;
  assign bus.err        = err_q;
  assign bus.err_opcode = err_op_q;

endmodule

// File: tb/tb_ie_loader.sv
// Directed bench for ie_loader: a full-size loader for encoding/handshake scenarios
// and a four-word loader for the capacity limit.
module tb_ie_loader;

  typedef struct {
    logic [6:0]  opcode;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [2:0]  func3;
    logic [6:0]  func7;
    logic [31:0] imm;
  } op_t;

  logic clk;
  logic rst_n;
  int   checks;
  int   failures;

  ie_loader_if #(.ADDR_WIDTH(8), .INSTRUCTON_WIDTH(32)) bif ();
  ie_loader_if #(.ADDR_WIDTH(2), .INSTRUCTON_WIDTH(32)) sif ();

  ie_loader u_big (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bif)
  );

  ie_loader #(.MEM_DEPTH(4)) u_small (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (sif)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  function automatic op_t mk(input logic [6:0] op, input logic [4:0] rd, input logic [4:0] rs1,
                             input logic [4:0] rs2, input logic [2:0] f3, input logic [6:0] f7,
                             input logic [31:0] imm);
    op_t o;
    o.opcode = op; o.rd = rd; o.rs1 = rs1; o.rs2 = rs2;
    o.func3 = f3; o.func7 = f7; o.imm = imm;
    return o;
  endfunction

  task automatic set_fields(input op_t o);
    bif.opcode = o.opcode; bif.rd = o.rd; bif.rs1 = o.rs1; bif.rs2 = o.rs2;
    bif.func3 = o.func3; bif.func7 = o.func7; bif.imm = o.imm;
    sif.opcode = o.opcode; sif.rd = o.rd; sif.rs1 = o.rs1; sif.rs2 = o.rs2;
    sif.func3 = o.func3; sif.func7 = o.func7; sif.imm = o.imm;
  endtask

  // Leaves the caller at a falling edge with the big loader in RUN.
  task automatic pulse_start_big();
    @(negedge clk); bif.start = 1'b1;
    @(negedge clk); bif.start = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    bif.start = 1'b0; bif.in_valid = 1'b0;
    sif.start = 1'b0; sif.in_valid = 1'b0;
    set_fields(mk(7'h33, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'd0));
    #12;
    checks++; if (bif.in_ready !== 1'b0) begin failures++; $display("FAIL reset_in_ready got=%b exp=0", bif.in_ready); end
    checks++; if (bif.mem_we !== 1'b0) begin failures++; $display("FAIL reset_mem_we got=%b exp=0", bif.mem_we); end
    checks++; if ({bif.full, bif.err} !== 2'b00) begin failures++; $display("FAIL reset_full_err got=%b exp=00", {bif.full, bif.err}); end
    checks++; if (bif.mem_addr !== 8'd0 || bif.mem_wdata !== 32'd0) begin failures++; $display("FAIL reset_addr_data got=%h/%h exp=0/0", bif.mem_addr, bif.mem_wdata); end
    checks++; if (bif.word_count !== 9'd0 || bif.err_opcode !== 7'd0) begin failures++; $display("FAIL reset_count_errop got=%0d/%h exp=0/0", bif.word_count, bif.err_opcode); end
    checks++; if (sif.in_ready !== 1'b0 || sif.full !== 1'b0) begin failures++; $display("FAIL reset_small got=%b%b exp=00", sif.in_ready, sif.full); end
    @(negedge clk); rst_n = 1'b1;
    // in_valid while IDLE must be ignored
    bif.in_valid = 1'b1;
    @(negedge clk);
    checks++; if (bif.mem_we !== 1'b0 || bif.in_ready !== 1'b0) begin failures++; $display("FAIL idle_ignore got_we=%b got_rdy=%b exp=0/0", bif.mem_we, bif.in_ready); end
    bif.in_valid = 1'b0;
  endtask

  task automatic test_single();
    pulse_start_big();
    checks++; if (bif.in_ready !== 1'b1) begin failures++; $display("FAIL single_ready got=%b exp=1", bif.in_ready); end
    set_fields(mk(7'h33, 5'd3, 5'd1, 5'd2, 3'd0, 7'd0, 32'd0));
    bif.in_valid = 1'b1;
    @(negedge clk); bif.in_valid = 1'b0;
    checks++; if (bif.mem_we !== 1'b1) begin failures++; $display("FAIL single_we got=%b exp=1", bif.mem_we); end
    checks++; if (bif.mem_addr !== 8'd0 || bif.mem_wdata !== 32'h002081B3) begin failures++; $display("FAIL single_write got=%h/%h exp=00/002081b3", bif.mem_addr, bif.mem_wdata); end
    checks++; if (bif.word_count !== 9'd1) begin failures++; $display("FAIL single_count got=%0d exp=1", bif.word_count); end
    @(negedge clk);
    checks++; if (bif.mem_we !== 1'b0) begin failures++; $display("FAIL single_we_drop got=%b exp=0", bif.mem_we); end
  endtask

  task automatic test_back_to_back();
    op_t         ops [7];
    logic [31:0] exp [7];
    ops[0] = mk(7'h13, 5'd1, 5'd0, 5'd9, 3'd0, 7'h55, 32'd5);         exp[0] = 32'h00500093;
    ops[1] = mk(7'h23, 5'd0, 5'd1, 5'd2, 3'd2, 7'd0, 32'd8);          exp[1] = 32'h0020A423;
    ops[2] = mk(7'h63, 5'd0, 5'd1, 5'd2, 3'd0, 7'd0, 32'd16);         exp[2] = 32'h00208863;
    ops[3] = mk(7'h37, 5'd5, 5'd7, 5'd0, 3'd0, 7'd0, 32'h12345000);   exp[3] = 32'h123452B7;
    ops[4] = mk(7'h6F, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd2048);       exp[4] = 32'h001000EF;
    ops[5] = mk(7'h13, 5'd3, 5'd1, 5'd0, 3'd1, 7'h00, 32'd4);         exp[5] = 32'h00409193;
    ops[6] = mk(7'h13, 5'd3, 5'd1, 5'd0, 3'd5, 7'h20, 32'd4);         exp[6] = 32'h4040D193;
    pulse_start_big();
    checks++; if (bif.word_count !== 9'd0) begin failures++; $display("FAIL b2b_restart_count got=%0d exp=0", bif.word_count); end
    for (int i = 0; i < 7; i++) begin
      set_fields(ops[i]);
      bif.in_valid = 1'b1;
      @(negedge clk);
      checks++;
      if (bif.mem_we !== 1'b1 || bif.mem_addr !== 8'(i) || bif.mem_wdata !== exp[i]) begin
        failures++;
        $display("FAIL b2b_write[%0d] got we=%b addr=%0d data=%h exp we=1 addr=%0d data=%h",
                 i, bif.mem_we, bif.mem_addr, bif.mem_wdata, i, exp[i]);
      end
    end
    bif.in_valid = 1'b0;
    @(negedge clk);
    checks++; if (bif.mem_we !== 1'b0 || bif.word_count !== 9'd7) begin failures++; $display("FAIL b2b_end got we=%b count=%0d exp=0/7", bif.mem_we, bif.word_count); end
  endtask

  task automatic test_unknown_opcode();
    pulse_start_big();
    set_fields(mk(7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd5));
    bif.in_valid = 1'b1;
    @(negedge clk);
    checks++; if (bif.mem_we !== 1'b1 || bif.mem_addr !== 8'd0 || bif.err !== 1'b0) begin failures++; $display("FAIL unk_first got we=%b addr=%0d err=%b exp=1/0/0", bif.mem_we, bif.mem_addr, bif.err); end
    set_fields(mk(7'h7F, 5'd4, 5'd4, 5'd4, 3'd0, 7'd0, 32'd0));
    @(negedge clk);
    checks++; if (bif.mem_we !== 1'b0 || bif.word_count !== 9'd1) begin failures++; $display("FAIL unk_nowrite got we=%b count=%0d exp=0/1", bif.mem_we, bif.word_count); end
    checks++; if (bif.err !== 1'b1 || bif.err_opcode !== 7'h7F) begin failures++; $display("FAIL unk_err got err=%b op=%h exp=1/7f", bif.err, bif.err_opcode); end
    set_fields(mk(7'h33, 5'd3, 5'd1, 5'd2, 3'd0, 7'd0, 32'd0));
    @(negedge clk);
    checks++; if (bif.mem_we !== 1'b1 || bif.mem_addr !== 8'd1 || bif.mem_wdata !== 32'h002081B3) begin failures++; $display("FAIL unk_contig got we=%b addr=%0d data=%h exp=1/1/002081b3", bif.mem_we, bif.mem_addr, bif.mem_wdata); end
    set_fields(mk(7'h0B, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'd0));
    @(negedge clk);
    checks++; if (bif.err_opcode !== 7'h7F || bif.err !== 1'b1 || bif.word_count !== 9'd2) begin failures++; $display("FAIL unk_sticky got op=%h err=%b count=%0d exp=7f/1/2", bif.err_opcode, bif.err, bif.word_count); end
    // start together with a valid field set: restart wins, nothing accepted
    set_fields(mk(7'h33, 5'd3, 5'd1, 5'd2, 3'd0, 7'd0, 32'd0));
    bif.start = 1'b1;
    @(negedge clk);
    bif.start = 1'b0; bif.in_valid = 1'b0;
    checks++; if (bif.mem_we !== 1'b0 || bif.word_count !== 9'd0) begin failures++; $display("FAIL start_wins got we=%b count=%0d exp=0/0", bif.mem_we, bif.word_count); end
    checks++; if (bif.err !== 1'b0 || bif.err_opcode !== 7'd0 || bif.in_ready !== 1'b1) begin failures++; $display("FAIL start_clear got err=%b op=%h rdy=%b exp=0/00/1", bif.err, bif.err_opcode, bif.in_ready); end
  endtask

  task automatic test_full();
    logic [31:0] exp_w;
    @(negedge clk); sif.start = 1'b1;
    @(negedge clk); sif.start = 1'b0;
    for (int k = 0; k < 5; k++) begin
      set_fields(mk(7'h33, 5'(k), 5'd1, 5'd2, 3'd0, 7'd0, 32'd0));
      sif.in_valid = 1'b1;
      @(negedge clk);
      exp_w = 32'h00208033 | (32'(k) << 7);
      checks++;
      if (k < 4) begin
        if (sif.mem_we !== 1'b1 || sif.mem_addr !== 2'(k) || sif.mem_wdata !== exp_w) begin
          failures++;
          $display("FAIL full_write[%0d] got we=%b addr=%0d data=%h exp we=1 addr=%0d data=%h",
                   k, sif.mem_we, sif.mem_addr, sif.mem_wdata, k, exp_w);
        end
      end else if (sif.mem_we !== 1'b0) begin
        failures++;
        $display("FAIL full_held_we got=%b exp=0", sif.mem_we);
      end
      checks++;
      if (sif.full !== (k >= 3) || sif.in_ready !== (k < 3)) begin
        failures++;
        $display("FAIL full_flag[%0d] got full=%b rdy=%b exp full=%b rdy=%b",
                 k, sif.full, sif.in_ready, (k >= 3), (k < 3));
      end
    end
    @(negedge clk);
    checks++; if (sif.mem_we !== 1'b0 || sif.word_count !== 3'd4 || sif.mem_addr !== 2'd3) begin failures++; $display("FAIL full_hold got we=%b count=%0d addr=%0d exp=0/4/3", sif.mem_we, sif.word_count, sif.mem_addr); end
    sif.start = 1'b1;
    @(negedge clk);
    sif.start = 1'b0; sif.in_valid = 1'b0;
    checks++; if (sif.word_count !== 3'd0 || sif.full !== 1'b0 || sif.in_ready !== 1'b1 || sif.mem_we !== 1'b0) begin failures++; $display("FAIL full_restart got count=%0d full=%b rdy=%b we=%b exp=0/0/1/0", sif.word_count, sif.full, sif.in_ready, sif.mem_we); end
  endtask

  task automatic test_reset_during_write();
    // A write already scheduled is killed by reset, including sticky error state.
    pulse_start_big();
    set_fields(mk(7'h7F, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'd0));
    bif.in_valid = 1'b1;
    @(negedge clk);
    set_fields(mk(7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd5));
    @(posedge clk); #1;
    checks++; if (bif.mem_we !== 1'b1 || bif.err !== 1'b1) begin failures++; $display("FAIL rst_pre got we=%b err=%b exp=1/1", bif.mem_we, bif.err); end
    rst_n = 1'b0; #1;
    checks++; if (bif.mem_we !== 1'b0 || bif.mem_wdata !== 32'd0 || bif.word_count !== 9'd0) begin failures++; $display("FAIL rst_async got we=%b data=%h count=%0d exp=0/0/0", bif.mem_we, bif.mem_wdata, bif.word_count); end
    checks++; if (bif.err !== 1'b0 || bif.err_opcode !== 7'd0 || bif.in_ready !== 1'b0) begin failures++; $display("FAIL rst_async_err got err=%b op=%h rdy=%b exp=0/00/0", bif.err, bif.err_opcode, bif.in_ready); end
    @(negedge clk); rst_n = 1'b1; bif.in_valid = 1'b0;
    // Reset asserted in the accept cycle, before the edge: nothing is written.
    pulse_start_big();
    set_fields(mk(7'h33, 5'd3, 5'd1, 5'd2, 3'd0, 7'd0, 32'd0));
    bif.in_valid = 1'b1;
    #2 rst_n = 1'b0;
    @(posedge clk); #1;
    checks++; if (bif.mem_we !== 1'b0 || bif.mem_addr !== 8'd0 || bif.in_ready !== 1'b0) begin failures++; $display("FAIL rst_accept got we=%b addr=%0d rdy=%b exp=0/0/0", bif.mem_we, bif.mem_addr, bif.in_ready); end
    @(negedge clk); rst_n = 1'b1; bif.in_valid = 1'b1;
    @(negedge clk); bif.in_valid = 1'b0;
    checks++; if (bif.in_ready !== 1'b0 || bif.mem_we !== 1'b0 || bif.full !== 1'b0) begin failures++; $display("FAIL rst_idle got rdy=%b we=%b full=%b exp=0/0/0", bif.in_ready, bif.mem_we, bif.full); end
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    test_reset();
    test_single();
    test_back_to_back();
    test_unknown_opcode();
    test_full();
    test_reset_during_write();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
